// File: rtl/input_debouncer.sv
// Button/switch front end: 2-flop sync, per-channel debounce, button press/release pulses.
// Optional auto-repeat pulses on held buttons when AUTOREPEAT_EN is defined.
module input_debouncer #(
   parameter int N_BTN           = 2,
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BTN_ACTIVE_LOW  = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [N_BTN-1:0] key_raw,
   input  logic [N_SW-1:0]  sw_raw,
   output logic [N_BTN-1:0] buttons_external_connection_export,
   output logic [N_SW-1:0]  switches_external_connection_export,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   localparam int N_CH = N_BTN + N_SW;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic REL_LVL = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   // Buttons idle at their released level, switches idle low.
   localparam logic [N_CH-1:0] RST_LVL = {{N_SW{1'b0}}, {N_BTN{REL_LVL}}};

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("input_debouncer: illegal timing parameters");
   end

   logic [N_CH-1:0]  raw_s;
   logic [N_CH-1:0]  sync1_r;
   logic [N_CH-1:0]  sync2_r;
   logic [N_CH-1:0]  stable_r;
   logic [N_CH-1:0]  level_r;
   logic [CNT_W-1:0] cnt_r [N_CH];
   logic [N_BTN-1:0] press_evt_s;
   logic [N_BTN-1:0] release_evt_s;
   logic [N_BTN-1:0] press_r;
   logic [N_BTN-1:0] release_r;

   assign raw_s = {sw_raw, key_raw};

   // Edge detect between the debounced level and the exported level.
   always_comb begin
      press_evt_s   = {N_BTN{1'b0}};
      release_evt_s = {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
         press_evt_s[i]   = (stable_r[i] != level_r[i]) && (stable_r[i] != REL_LVL);
         release_evt_s[i] = (stable_r[i] != level_r[i]) && (stable_r[i] == REL_LVL);
      end
   end

   // Synchronizer, debounce counters, exported level and registered pulses.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync1_r   <= RST_LVL;
         sync2_r   <= RST_LVL;
         stable_r  <= RST_LVL;
         level_r   <= RST_LVL;
         press_r   <= {N_BTN{1'b0}};
         release_r <= {N_BTN{1'b0}};
         for (int i = 0; i < N_CH; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         sync1_r   <= raw_s;
         sync2_r   <= sync1_r;
         level_r   <= stable_r;
         press_r   <= press_evt_s;
         release_r <= release_evt_s;
         for (int i = 0; i < N_CH; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
               cnt_r[i] <= {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
               stable_r[i] <= sync2_r[i];
               cnt_r[i]    <= {CNT_W{1'b0}};
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_W'(1'b1);
            end
         end
      end
   end

   assign buttons_external_connection_export  = level_r[N_BTN-1:0];
   assign switches_external_connection_export = level_r[N_CH-1:N_BTN];
   assign btn_press   = press_r;
   assign btn_release = release_r;

`ifdef AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      REL       = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } rpt_state_e;

   rpt_state_e       state_r   [N_BTN];
   logic [RPT_W-1:0] rpt_cnt_r [N_BTN];
   logic [N_BTN-1:0] repeat_r;

   // Per-button auto-repeat FSM; a release always wins over a due repeat pulse.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         repeat_r <= {N_BTN{1'b0}};
         for (int i = 0; i < N_BTN; i++) begin
            state_r[i]   <= REL;
            rpt_cnt_r[i] <= {RPT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            repeat_r[i] <= 1'b0;
            if (release_evt_s[i]) begin
               state_r[i]   <= REL;
               rpt_cnt_r[i] <= {RPT_W{1'b0}};
            end else begin
               case (state_r[i])
                  REL: begin
                     if (press_evt_s[i]) begin
                        state_r[i]   <= HOLD_WAIT;
                        rpt_cnt_r[i] <= {RPT_W{1'b0}};
                     end else begin
                        rpt_cnt_r[i] <= {RPT_W{1'b0}};
                     end
                  end
                  HOLD_WAIT: begin
                     if (rpt_cnt_r[i] == DELAY_LAST) begin
                        state_r[i]   <= REPEAT;
                        rpt_cnt_r[i] <= {RPT_W{1'b0}};
                        repeat_r[i]  <= 1'b1;
                     end else begin
                        rpt_cnt_r[i] <= rpt_cnt_r[i] + RPT_W'(1'b1);
                     end
                  end
                  REPEAT: begin
                     if (rpt_cnt_r[i] == RATE_LAST) begin
                        rpt_cnt_r[i] <= {RPT_W{1'b0}};
                        repeat_r[i]  <= 1'b1;
                     end else begin
                        rpt_cnt_r[i] <= rpt_cnt_r[i] + RPT_W'(1'b1);
                     end
                  end
                  default: begin
                     state_r[i]   <= REL;
                     rpt_cnt_r[i] <= {RPT_W{1'b0}};
                  end
               endcase
            end
         end
      end
   end

   assign btn_repeat = repeat_r;
`else
   assign btn_repeat = {N_BTN{1'b0}};
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: expectations are queued per cycle as stimulus
// is scheduled and compared on the falling edge after each rising edge.
module tb_input_debouncer;

   localparam int N_BTN = 2;
   localparam int N_SW  = 10;
`ifdef AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic             clk;
   logic             reset_reset;
   logic [N_BTN-1:0] key_raw;
   logic [N_SW-1:0]  sw_raw;
   logic [N_BTN-1:0] btn_exp_lvl;
   logic [N_SW-1:0]  sw_exp_lvl;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_repeat;

   input_debouncer #(
      .N_BTN(N_BTN), .N_SW(N_SW), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1),
      .REPEAT_DELAY(20), .REPEAT_RATE(8)
   ) dut (
      .clk_clk(clk),
      .reset_reset(reset_reset),
      .key_raw(key_raw),
      .sw_raw(sw_raw),
      .buttons_external_connection_export(btn_exp_lvl),
      .switches_external_connection_export(sw_exp_lvl),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_repeat(btn_repeat)
   );

   typedef struct {
      int          at;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   press_cnt = 0;
   int   release_cnt = 0;
   int   repeat_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic string kind_name(input int kind);
      case (kind)
         0: return "btn_export";
         1: return "sw_export";
         2: return "btn_press";
         3: return "btn_release";
         4: return "btn_repeat";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         0: return 32'(btn_exp_lvl);
         1: return 32'(sw_exp_lvl);
         2: return 32'(btn_press);
         3: return 32'(btn_release);
         4: return 32'(btn_repeat);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push_exp(input int at, input int kind, input logic [31:0] val);
      exp_t e;
      e.at = at;
      e.kind = kind;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic exp_range(input int from, input int to, input int kind, input logic [31:0] val);
      for (int c = from; c <= to; c++) push_exp(c, kind, val);
   endtask

   task automatic exp_pulse(input int from, input int to, input int kind, input int hit,
                            input logic [31:0] val);
      for (int c = from; c <= to; c++) push_exp(c, kind, (c == hit) ? val : 32'h0);
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: count pulses and retire every expectation due this cycle.
   always @(negedge clk) begin
      press_cnt   += $countones(btn_press);
      release_cnt += $countones(btn_release);
      repeat_cnt  += $countones(btn_repeat);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].at == cyc) begin
            check_value($sformatf("%s@%0d", kind_name(exp_q[i].kind), cyc),
                        observe(exp_q[i].kind), exp_q[i].val);
            exp_q.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int r0;
      reset_reset = 1'b1;
      key_raw     = 2'b11;
      sw_raw      = 10'h000;

      // Reset and idle
      exp_range(1, 8, 0, 32'h3);
      exp_range(1, 8, 1, 32'h0);
      exp_range(1, 8, 2, 32'h0);
      exp_range(1, 8, 3, 32'h0);
      exp_range(1, 8, 4, 32'h0);
      // Single press / release on button 0
      exp_range(10, 15, 0, 32'h3);
      exp_range(16, 45, 0, 32'h2);
      exp_range(46, 50, 0, 32'h3);
      exp_pulse(10, 50, 2, 16, 32'h1);
      exp_pulse(10, 50, 3, 46, 32'h1);
      // Bouncing then settle
      exp_range(60, 83, 0, 32'h3);
      exp_range(84, 105, 0, 32'h2);
      exp_range(106, 110, 0, 32'h3);
      exp_pulse(60, 90, 2, 84, 32'h1);
      exp_pulse(100, 110, 3, 106, 32'h1);
      // Switches: step, 2-cycle glitch, 4-cycle accept, 3-cycle reject
      exp_range(110, 125, 1, 32'h000);
      exp_range(126, 165, 1, 32'h2A5);
      exp_range(166, 169, 1, 32'h2AD);
      exp_range(170, 241, 1, 32'h2A5);
      // Both buttons together, then reset mid-debounce
      exp_range(195, 205, 0, 32'h3);
      exp_range(206, 225, 0, 32'h0);
      exp_range(226, 249, 0, 32'h3);
      exp_pulse(200, 210, 2, 206, 32'h3);
      exp_pulse(220, 230, 3, 226, 32'h3);
      exp_pulse(240, 255, 2, 250, 32'h3);
      exp_range(240, 249, 3, 32'h0);
      exp_range(240, 249, 4, 32'h0);
      exp_range(242, 249, 1, 32'h000);
      exp_range(250, 260, 1, 32'h2A5);
      exp_range(250, 275, 0, 32'h0);
      exp_range(276, 280, 0, 32'h3);
      exp_pulse(270, 280, 3, 276, 32'h3);
      // Button 1 held: auto-repeat
      exp_range(300, 305, 0, 32'h3);
      exp_range(306, 365, 0, 32'h1);
      exp_range(366, 370, 0, 32'h3);
      exp_pulse(300, 370, 2, 306, 32'h2);
      exp_pulse(300, 370, 3, 366, 32'h2);
      for (int c = 300; c <= 370; c++) begin
         push_exp(c, 4, (AR && c >= 326 && c < 366 && ((c - 326) % 8) == 0) ? 32'h2 : 32'h0);
      end

      wait_edge(3);
      reset_reset = 1'b0;

      wait_edge(9);
      key_raw = 2'b10;
      wait_edge(39);
      key_raw = 2'b11;

      wait_edge(55);
      p0 = press_cnt;
      for (int k = 0; k < 6; k++) begin
         wait_edge(59 + 3 * k);
         key_raw[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      end
      wait_edge(77);
      key_raw[0] = 1'b0;
      wait_edge(99);
      check_value("bounce_press_count", 32'(press_cnt - p0), 32'd1);
      key_raw = 2'b11;

      wait_edge(119);
      sw_raw = 10'h2A5;
      wait_edge(139);
      sw_raw = 10'h2AD;
      wait_edge(141);
      sw_raw = 10'h2A5;
      wait_edge(159);
      sw_raw = 10'h2AD;
      wait_edge(163);
      sw_raw = 10'h2A5;
      wait_edge(179);
      sw_raw = 10'h2AD;
      wait_edge(182);
      sw_raw = 10'h2A5;

      wait_edge(199);
      key_raw = 2'b00;
      wait_edge(219);
      key_raw = 2'b11;
      wait_edge(239);
      key_raw = 2'b00;
      wait_edge(241);
      reset_reset = 1'b1;
      wait_edge(243);
      reset_reset = 1'b0;
      wait_edge(269);
      key_raw = 2'b11;

      wait_edge(299);
      r0 = repeat_cnt;
      key_raw = 2'b01;
      wait_edge(359);
      key_raw = 2'b11;
      wait_edge(375);
      check_value("repeat_count", 32'(repeat_cnt - r0), AR ? 32'd5 : 32'd0);

      wait_edge(380);
      check_value("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
